motion_diff_ctrl: RTL and testbench

MOTION_DIFF_CTRL -- requirements
Module: motion_diff_ctrl

---
 rtl/motion_diff_ctrl_pkg.sv | 22 ++
 rtl/motion_diff_ctrl_abs_diff.sv | 16 +
 rtl/motion_diff_ctrl.sv | 149 ++++++++++++++
 tb/tb_motion_diff_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/motion_diff_ctrl_pkg.sv
// rtl/motion_diff_ctrl_pkg.sv - shared types and constants for the motion difference controller
//
// Purpose: FSM state encoding, lane count and the accumulator width derivation
//          used by motion_diff_ctrl.
// Ports:   none (package).
package motion_diff_ctrl_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Accumulator must hold every lane of every word changing: 0..NUM_LANES*num_words.
  function automatic int cnt_width(input int num_words);
    return $clog2(NUM_LANES * num_words + 1);
  endfunction

endpackage

// File: rtl/motion_diff_ctrl_abs_diff.sv
// rtl/motion_diff_ctrl_abs_diff.sv - unsigned absolute difference of two lane values
//
// Purpose: diff = |a - b| for one unsigned pixel lane, purely combinational.
// Ports:   a, b  - WIDTH-bit unsigned operands
//          diff  - WIDTH-bit unsigned absolute difference
module motion_diff_ctrl_abs_diff #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/motion_diff_ctrl.sv
// rtl/motion_diff_ctrl.sv - frame-to-frame changed-lane counter with motion flag
//
// Purpose: reads NUM_WORDS 4-lane words from the current and previous frame
//          memories, counts lanes whose absolute difference exceeds pix_thresh
//          and flags motion when the count reaches motion_thresh.
// Ports:   clk, rst_n           - clock, asynchronous active-low reset
//          start                - begin a frame (accepted only in IDLE)
//          pix_thresh           - per-lane change threshold (sampled on start)
//          motion_thresh        - changed-lane count that flags motion (sampled on start)
//          rd_en, rd_addr       - shared read strobe/address to both memories
//          new_data, old_data   - returned words, valid one cycle after rd_en
//          busy                 - high in RUN and DRAIN
//          done                 - single-cycle completion pulse
//          change_count, motion - result of the last completed frame
module motion_diff_ctrl
  import motion_diff_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int NUM_WORDS = 256,
  parameter  int ADDR_W    = 8,
  localparam int CNT_W     = cnt_width(NUM_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           pix_thresh,
  input  logic [CNT_W-1:0]           motion_thresh,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_LANES*WIDTH-1:0] new_data,
  input  logic [NUM_LANES*WIDTH-1:0] old_data,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           change_count,
  output logic                       motion
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t               state;
  logic [WIDTH-1:0]     pix_th;
  logic [CNT_W-1:0]     mot_th;
  logic                 drain_cnt;
  logic                 data_vld;
  logic                 s1_valid;
  logic [2:0]           s1_cnt;
  logic [CNT_W-1:0]     acc;
  logic [CNT_W-1:0]     acc_next;
  logic [CNT_W:0]       acc_sum;
  logic [NUM_LANES-1:0] lane_hit;
  logic [2:0]           hit_sum;
  logic [WIDTH-1:0]     lane_diff [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    motion_diff_ctrl_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
      .a    (new_data[g*WIDTH +: WIDTH]),
      .b    (old_data[g*WIDTH +: WIDTH]),
      .diff (lane_diff[g])
    );
    assign lane_hit[g] = (lane_diff[g] > pix_th);
  end

  always_comb begin
    hit_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_sum = hit_sum + {2'b00, lane_hit[i]};
    end
  end

  // Width already covers the maximum count; the clamp keeps a wrap impossible
  // even if the parameters are pushed outside their intended relationship.
  always_comb begin
    acc_sum  = {1'b0, acc} + (CNT_W+1)'(s1_valid ? s1_cnt : 3'd0);
    acc_next = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
  end

  // Stage 1: data_vld marks the cycle the memories return a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld <= 1'b0;
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
    end else begin
      data_vld <= rd_en;
      s1_valid <= data_vld;
      if (data_vld) s1_cnt <= hit_sum;
    end
  end

  // FSM plus stage-2 accumulator. The final word's hit count is still in
  // stage 1 on the last DRAIN cycle, so the result is loaded from acc_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      change_count <= '0;
      motion       <= 1'b0;
      pix_th       <= '0;
      mot_th       <= '0;
      drain_cnt    <= 1'b0;
      acc          <= '0;
    end else begin
      done <= 1'b0;
      acc  <= acc_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
            pix_th  <= pix_thresh;
            mot_th  <= motion_thresh;
            acc     <= '0;
          end
        end
        ST_RUN: begin
          if (rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            change_count <= acc_next;
            motion       <= (acc_next >= mot_th);
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_diff_ctrl.sv
// tb/tb_motion_diff_ctrl.sv - directed self-checking bench for motion_diff_ctrl
module tb_motion_diff_ctrl;

  localparam int WIDTH     = 4;
  localparam int NUM_WORDS = 4;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 5;
  localparam int LATENCY   = NUM_WORDS + 3;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [WIDTH-1:0]     pix_thresh;
  logic [CNT_W-1:0]     motion_thresh;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [4*WIDTH-1:0]   new_data;
  logic [4*WIDTH-1:0]   old_data;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     change_count;
  logic                 motion;

  logic [15:0] mem_new [NUM_WORDS];
  logic [15:0] mem_old [NUM_WORDS];

  int n_tests = 0;
  int n_fail  = 0;

  motion_diff_ctrl #(
    .WIDTH     (WIDTH),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pix_thresh    (pix_thresh),
    .motion_thresh (motion_thresh),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .new_data      (new_data),
    .old_data      (old_data),
    .busy          (busy),
    .done          (done),
    .change_count  (change_count),
    .motion        (motion)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memories with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      new_data <= mem_new[rd_addr];
      old_data <= mem_old[rd_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] n, input logic [15:0] o);
    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_new[i] = n;
      mem_old[i] = o;
    end
  endtask

  // Runs one frame. Thresholds are scrambled mid-frame to prove they were
  // sampled at start. pulse_run pokes start during RUN; chain raises start in
  // the DONE cycle and leaves it high so the next call starts back-to-back.
  task automatic run_frame(input string nm, input logic [3:0] pix, input logic [4:0] mth,
                           input bit pulse_run, input bit chain,
                           input int exp_cnt, input bit exp_mot);
    int lat = 0;
    int rd_cnt = 0;
    int addr_err = 0;
    int extra_done = 0;
    @(negedge clk);
    start = 1'b1;
    pix_thresh = pix;
    motion_thresh = mth;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        pix_thresh = 4'd0;
        motion_thresh = 5'd0;
      end
      if (pulse_run && k == 3) start = 1'b1;
      if (pulse_run && k == 4) start = 1'b0;
      if (rd_en) begin
        if (rd_addr != 2'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, lat, LATENCY);
    check({nm, "_rd_count"}, rd_cnt, NUM_WORDS);
    check({nm, "_addr_seq_err"}, addr_err, 0);
    check({nm, "_count"}, change_count, exp_cnt);
    check({nm, "_motion"}, motion, exp_mot);
    if (chain) begin
      start = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check({nm, "_extra_done"}, extra_done, 0);
      check({nm, "_busy_idle"}, busy, 0);
      check({nm, "_count_hold"}, change_count, exp_cnt);
    end
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0;
    start = 1'b0;
    pix_thresh = '0;
    motion_thresh = '0;
    fill(16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", change_count, 0);
    check("rst_motion", motion, 0);
    rst_n = 1'b1;

    fill(16'h5A3C, 16'h5A3C);
    run_frame("ident", 4'd0, 5'd1, 1'b0, 1'b0, 0, 1'b0);

    fill(16'hFFFF, 16'h0000);
    run_frame("all_t14", 4'd14, 5'd1, 1'b0, 1'b0, 16, 1'b1);
    run_frame("all_t15", 4'd15, 5'd1, 1'b0, 1'b0, 0, 1'b0);

    // Lane diffs 3,1,1,3 -> two hits per word above threshold 2.
    fill(16'h1234, 16'h4321);
    run_frame("mixed", 4'd2, 5'd8, 1'b0, 1'b0, 8, 1'b1);

    fill(16'hFFFF, 16'h0000);
    run_frame("ignore", 4'd14, 5'd1, 1'b1, 1'b1, 16, 1'b1);
    fill(16'h1234, 16'h4321);
    run_frame("b2b", 4'd2, 5'd9, 1'b0, 1'b0, 8, 1'b0);

    // Abort mid-frame once address 2 is on the bus.
    fill(16'hFFFF, 16'h0000);
    @(negedge clk);
    start = 1'b1;
    pix_thresh = 4'd14;
    motion_thresh = 5'd1;
    done_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (rd_en && rd_addr == 2'd2) break;
    end
    check("abort_at_addr2", {rd_en, rd_addr}, {1'b1, 2'd2});
    rst_n = 1'b0;
    #1;
    check("abort_rd_en", rd_en, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", change_count, 0);
    check("abort_motion", motion, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    fill(16'h1234, 16'h4321);
    run_frame("post_rst", 4'd2, 5'd8, 1'b0, 1'b0, 8, 1'b1);

    fill(16'h9C61, 16'h9C61);
    run_frame("mth0", 4'd0, 5'd0, 1'b0, 1'b0, 0, 1'b1);
    fill(16'hFFFF, 16'h0000);
    run_frame("mth17", 4'd0, 5'd17, 1'b0, 1'b0, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
